// File: rtl/div_unit_pkg.sv
// Shared definitions for the sequential HI/LO divider.
// State encoding, default width and counter sizing.
package div_unit_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        ZERO = 3'd4
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep or restore the remainder.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         quo_bit
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // rem < divisor always holds, so bit W of trial is its sign
    assign shifted  = {rem, dividend_bit};
    assign trial    = shifted - {1'b0, divisor};
    assign quo_bit  = ~trial[W];
    assign rem_next = quo_bit ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/div_unit.sv
// Sequential restoring divider for DIV/DIVU: quotient to LO,
// remainder to HI, one-cycle divide-by-zero flag.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clock,
    input  logic             Reset_N,
    input  logic             Div_Control,
    input  logic             Div_Unsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI_Out,
    output logic [WIDTH-1:0] LO_Out,
    output logic             Div_Busy,
    output logic             Div_Done,
    output logic             Div_Zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             uns;
    logic             sign_a;
    logic             sign_b;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] rem_next;
    logic             quo_bit;

    assign neg_a = ~Div_Unsigned & A[WIDTH-1];
    assign neg_b = ~Div_Unsigned & B[WIDTH-1];

    div_step #(.W(WIDTH)) u_step (
        .rem          (rem),
        .dividend_bit (quo[WIDTH-1]),
        .divisor      (dvs),
        .rem_next     (rem_next),
        .quo_bit      (quo_bit)
    );

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            uns      <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            HI_Out   <= '0;
            LO_Out   <= '0;
            Div_Busy <= 1'b0;
            Div_Done <= 1'b0;
            Div_Zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    Div_Done <= 1'b0;
                    Div_Zero <= 1'b0;
                    if (Div_Control) begin
                        uns      <= Div_Unsigned;
                        sign_a   <= neg_a;
                        sign_b   <= neg_b;
                        quo      <= neg_a ? -A : A;
                        dvs      <= neg_b ? -B : B;
                        rem      <= '0;
                        cnt      <= '0;
                        Div_Busy <= 1'b1;
                        state    <= (B == '0) ? ZERO : RUN;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    quo <= {quo[WIDTH-2:0], quo_bit};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // quotient truncates toward zero; remainder follows dividend
                    LO_Out   <= (!uns && (sign_a ^ sign_b)) ? -quo : quo;
                    HI_Out   <= (!uns && sign_a) ? -rem : rem;
                    Div_Done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    Div_Done <= 1'b0;
                    Div_Busy <= 1'b0;
                    state    <= IDLE;
                end
                ZERO: begin
                    Div_Zero <= 1'b1;
                    Div_Busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    Div_Busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random ops
// against an arithmetic model, and an abort-by-reset sequence.
module tb_div_unit;

    logic        Clock;
    logic        Reset_N;
    logic        Div_Control;
    logic        Div_Unsigned;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI_Out;
    logic [31:0] LO_Out;
    logic        Div_Busy;
    logic        Div_Done;
    logic        Div_Zero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .Clock        (Clock),
        .Reset_N      (Reset_N),
        .Div_Control  (Div_Control),
        .Div_Unsigned (Div_Unsigned),
        .A            (A),
        .B            (B),
        .HI_Out       (HI_Out),
        .LO_Out       (LO_Out),
        .Div_Busy     (Div_Busy),
        .Div_Done     (Div_Done),
        .Div_Zero     (Div_Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        u;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Plain integer arithmetic: truncating division, remainder takes dividend sign
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           input logic u, output logic [31:0] q,
                           output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (u) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endtask

    // Start an op, then wait (bounded) for Done or Zero; A/B/U scrambled after capture
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic u, input int pulse_at,
                         output int lat, output logic dn, output logic zr);
        @(negedge Clock);
        A = a; B = b; Div_Unsigned = u; Div_Control = 1'b1;
        @(posedge Clock); #1;
        Div_Control = 1'b0;
        A = $urandom; B = $urandom; Div_Unsigned = 1'($urandom);
        chk("busy_after_start", {31'b0, Div_Busy}, 32'd1);
        lat = 0; dn = 1'b0; zr = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == pulse_at) Div_Control = 1'b1;
            @(posedge Clock); #1;
            Div_Control = 1'b0;
            A = $urandom; B = $urandom; Div_Unsigned = 1'($urandom);
            if (Div_Done || Div_Zero) begin
                lat = k; dn = Div_Done; zr = Div_Zero;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic u,
                             input logic [31:0] elo, input logic [31:0] ehi,
                             input logic ezero, input int pulse_at);
        int   lat;
        logic dn, zr;
        do_op(a, b, u, pulse_at, lat, dn, zr);
        chk({tag, "_latency"}, lat, ezero ? 32'd1 : 32'd33);
        chk({tag, "_done"}, {31'b0, dn}, {31'b0, ~ezero});
        chk({tag, "_zero"}, {31'b0, zr}, {31'b0, ezero});
        chk({tag, "_lo"}, LO_Out, elo);
        chk({tag, "_hi"}, HI_Out, ehi);
        @(posedge Clock); #1;
        chk({tag, "_pulse_end"}, {30'b0, Div_Done, Div_Zero}, 32'd0);
        chk({tag, "_idle_busy"}, {31'b0, Div_Busy}, 32'd0);
        chk({tag, "_lo_hold"}, LO_Out, elo);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] ra, rb, q, r, plo, phi;
        logic        ru;

        Reset_N = 1'b0; Div_Control = 1'b0; Div_Unsigned = 1'b0;
        A = '0; B = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_hi", HI_Out, 32'd0);
        chk("rst_lo", LO_Out, 32'd0);
        chk("rst_flags", {29'b0, Div_Busy, Div_Done, Div_Zero}, 32'd0);
        @(negedge Clock);
        Reset_N = 1'b1;

        vecs[0] = '{32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 1'b0};
        vecs[1] = '{32'd5, 32'd0, 1'b0, 32'd3, 32'd1, 1'b1};
        vecs[2] = '{32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{32'd7, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 32'd1, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'h10, 1'b1, 32'h0FFFFFFF, 32'hF, 1'b0};
        vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1, 32'd0, 1'b0};
        vecs[7] = '{32'd9, 32'd0, 1'b1, 32'd1, 32'd0, 1'b1};

        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].u,
                      vecs[i].lo, vecs[i].hi, vecs[i].zero, 0);
        end

        plo = LO_Out; phi = HI_Out;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            ru = 1'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1, 2: rb = 32'($urandom_range(1, 20));
                3: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (rb == 32'd0) begin
                q = plo; r = phi;
            end else begin
                ref_div(ra, rb, ru, q, r);
            end
            run_check($sformatf("rnd%0d", i), ra, rb, ru, q, r,
                      rb == 32'd0, 0);
            plo = q; phi = r;
        end

        // A second request mid-operation must be ignored
        run_check("ignored_start", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 10);

        // Abort by asynchronous reset mid-run
        @(negedge Clock);
        A = 32'd1000; B = 32'd3; Div_Unsigned = 1'b1; Div_Control = 1'b1;
        @(posedge Clock); #1;
        Div_Control = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 10) Div_Control = 1'b1;
            @(posedge Clock); #1;
            Div_Control = 1'b0;
        end
        #1;
        Reset_N = 1'b0;
        #1;
        chk("abort_hi", HI_Out, 32'd0);
        chk("abort_lo", LO_Out, 32'd0);
        chk("abort_flags", {29'b0, Div_Busy, Div_Done, Div_Zero}, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset_N = 1'b1;
        run_check("post_reset", 32'hFFFFFF9C, 32'd7, 1'b0,
                  32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
